// File: rtl/ram_dp_param.sv
// Simple dual-port RAM (one write port, one read port, one clock) with byte-lane writes,
// a configurable read latency, a selectable read-during-write result and a post-reset clear engine.
module ram_dp_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_enb,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic                  rd_enb,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  init_busy,
    output logic                  acc_err,
    output logic                  dbg_state
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    if ((DATA_W % 8) != 0 || RD_LAT < 1 || RD_LAT > 3) begin : g_param_err
        $fatal(1, "ram_dp_param: DATA_W must be a multiple of 8 and RD_LAT must be 1..3");
    end

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic [ADDR_W-1:0]   w_clr_cnt_nxt;
    logic                w_busy;
    logic                w_wr_fire;
    logic                w_rd_fire;
    logic [DATA_W-1:0]   w_rd_word;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [RD_LAT-1:0]   r_vld;
    logic [DATA_W-1:0]   r_dat [RD_LAT];
    logic                r_acc_err;

    // Handshake: there is no backpressure. A request (wr_enb / rd_enb) is accepted on a
    // rising edge only while init_busy=0; each accepted read yields exactly one rd_valid
    // pulse RD_LAT cycles later, in request order. Requests while busy are dropped and flagged.
    assign w_busy    = (r_state == CLEAR);
    assign w_wr_fire = !w_busy && wr_enb;
    assign w_rd_fire = !w_busy && rd_enb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            CLEAR: begin
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == ADDR_W'(DEPTH - 1)) begin
                    w_state_nxt = READY;
                end
            end
            READY:   w_state_nxt = READY;
            default: w_state_nxt = CLEAR;
        endcase
    end

    // Storage has no reset; the clear engine owns the write port while busy.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_fire) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    r_mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Old-data mode falls out of reading the array before the write lands; new-data mode
    // forwards the enabled write lanes over the stored word.
    always_comb begin
        w_rd_word = r_mem[rd_addr];
        if (RDW_MODE != 0 && w_wr_fire && (wr_addr == rd_addr)) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    w_rd_word[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
    end

    // Data stages only advance behind a valid bit, so the last stage holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                r_dat[k] <= '0;
            end
        end else begin
            r_vld[0] <= w_rd_fire;
            if (w_rd_fire) begin
                r_dat[0] <= w_rd_word;
            end
            for (int k = 1; k < RD_LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) begin
                    r_dat[k] <= r_dat[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_err <= 1'b0;
        end else begin
            r_acc_err <= w_busy && (wr_enb || rd_enb);
        end
    end

    assign rd_data   = r_dat[RD_LAT-1];
    assign rd_valid  = r_vld[RD_LAT-1];
    assign init_busy = w_busy;
    assign acc_err   = r_acc_err;
    assign dbg_state = r_state;

endmodule
